// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart transmitter between four byte requesters.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   req_valid[3:0]      per-requester byte pending
//   req_byte0..3        requester data bytes, stable while valid
//   req_ack[3:0]        one-cycle consume pulse to the granted requester
//   tx_byte, tx_start   byte and one-cycle strobe to the uart
//   tx_busy             uart transmitting status
//   grant_id            requester owning the current transfer
//   timeout_err         sticky: uart never went busy after tx_start
//   err_clear           clears timeout_err (a same-cycle timeout wins)
//
// Parameter TIMEOUT_CYCLES (1..65535): WAIT_BUSY cycles before a launch is abandoned.
// Macro UART_ARB_FIXED_PRIORITY_EN: when defined, requester 0 has highest
// priority; otherwise round-robin starting after the last completed grant.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req_valid,
    input  logic [7:0] req_byte0,
    input  logic [7:0] req_byte1,
    input  logic [7:0] req_byte2,
    input  logic [7:0] req_byte3,
    output logic [3:0] req_ack,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [1:0] grant_id,
    output logic       timeout_err,
    input  logic       err_clear
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       req_ack_d;
    logic [7:0]       tx_byte_d;
    logic             tx_start_d;
    logic [1:0]       grant_id_d;
    logic             timeout_err_d;

    logic [1:0]       winner_c;
    logic [7:0]       win_byte_c;

`ifdef UART_ARB_FIXED_PRIORITY_EN
    // Lowest-index valid requester wins.
    always_comb begin
        winner_c = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[k]) winner_c = 2'(k);
        end
    end
`else
    logic [1:0] last_grant;

    // Only completed transfers rotate priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 2'd3;
        end else if (state == WAIT_DONE && !tx_busy) begin
            last_grant <= grant_id;
        end
    end

    // Search last_grant+1 .. last_grant; scanning far-to-near leaves the nearest hit.
    always_comb begin
        logic [1:0] idx;
        winner_c = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_grant + 2'(k);
            if (req_valid[idx]) winner_c = idx;
        end
    end
`endif

    // Winner's data byte.
    always_comb begin
        case (winner_c)
            2'd0:    win_byte_c = req_byte0;
            2'd1:    win_byte_c = req_byte1;
            2'd2:    win_byte_c = req_byte2;
            default: win_byte_c = req_byte3;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ack     <= '0;
            tx_byte     <= '0;
            tx_start    <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            req_ack     <= req_ack_d;
            tx_byte     <= tx_byte_d;
            tx_start    <= tx_start_d;
            grant_id    <= grant_id_d;
            timeout_err <= timeout_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        req_ack_d     = '0;
        tx_start_d    = 1'b0;
        tx_byte_d     = tx_byte;
        grant_id_d    = grant_id;
        timeout_err_d = timeout_err;

        if (err_clear) timeout_err_d = 1'b0;

        case (state)
            IDLE: begin
                if ((|req_valid) && !tx_busy) begin
                    tx_byte_d  = win_byte_c;
                    grant_id_d = winner_c;
                    req_ack_d  = 4'b0001 << winner_c;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    // Abandon the launch; a timeout overrides err_clear.
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (TIMEOUT_CYCLES = 16).
module tb_uart_tx_arbiter;

    localparam int unsigned TO = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [7:0] rb [4];
    logic [3:0] req_ack;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy;
    logic [1:0] grant_id;
    logic       timeout_err;
    logic       err_clear;

    logic       use_auto;
    logic       busy_man;
    logic       busy_auto;
    int unsigned uart_gap, uart_len, u_dly, u_left;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid),
        .req_byte0(rb[0]), .req_byte1(rb[1]), .req_byte2(rb[2]), .req_byte3(rb[3]),
        .req_ack(req_ack), .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .timeout_err(timeout_err), .err_clear(err_clear)
    );

    initial forever #5 clock = ~clock;

    // Uart model: busy rises uart_gap edges after tx_start, for uart_len cycles.
    always @(posedge clock) begin
        if (reset) begin
            u_dly  <= 0;
            u_left <= 0;
        end else begin
            if (u_dly != 0) begin
                u_dly <= u_dly - 1;
                if (u_dly == 1) u_left <= uart_len;
            end else if (u_left != 0) begin
                u_left <= u_left - 1;
            end
            if (tx_start) u_dly <= uart_gap;
        end
    end
    assign busy_auto = (u_left != 0);
    assign tx_busy   = use_auto ? busy_auto : busy_man;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration rule.
    function automatic int pick(input logic [3:0] v, input int last);
`ifdef UART_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       busy;
        logic [3:0] ack;
        logic       start;
        logic [1:0] gid;
        logic [7:0] byt;
    } vec_t;

    vec_t vecs [12];

    logic [3:0] pv;
    logic       pb;
    logic [7:0] pbytes [4];
    logic       in_flight, seen_busy, pending_start, have_grant;
    int         m_last, m_gid, w, exp_id, acks, waited;
    logic [7:0] m_byte;

    initial begin
        reset = 1'b1; req_valid = '0; busy_man = 1'b0; use_auto = 1'b0; err_clear = 1'b0;
        uart_gap = 3; uart_len = 10;
        rb[0] = 8'hA5; rb[1] = 8'h3C; rb[2] = 8'h5A; rb[3] = 8'hC3;

        // Reset state
        tick(); tick();
        check("rst_ack", req_ack, 4'b0);
        check("rst_start", tx_start, 1'b0);
        check("rst_byte", tx_byte, 8'h00);
        check("rst_gid", grant_id, 2'd0);
        check("rst_err", timeout_err, 1'b0);
        reset = 1'b0;

        // Single transfer, then a grant held off by tx_busy in IDLE
        vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 8'hA5};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA5};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5};
        vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5};
        vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5};
        vecs[6]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5};
        vecs[7]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5};
        vecs[8]  = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd1, 8'h3C};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h3C};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h3C};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 8'h3C};
        for (int r = 0; r < 12; r++) begin
            req_valid = vecs[r].valid;
            busy_man  = vecs[r].busy;
            tick();
            check($sformatf("vec%0d_ack", r), req_ack, vecs[r].ack);
            check($sformatf("vec%0d_start", r), tx_start, vecs[r].start);
            check($sformatf("vec%0d_gid", r), grant_id, vecs[r].gid);
            check($sformatf("vec%0d_byte", r), tx_byte, vecs[r].byt);
        end

        // Timeout: busy never rises
        busy_man = 1'b0;
        req_valid = 4'b0001;
        tick();
        check("to_ack", req_ack, 4'b0001);
        req_valid = 4'b0000;
        tick();
        check("to_start", tx_start, 1'b1);
        for (int n = 1; n < TO; n++) begin
            tick();
            check($sformatf("to_err_early%0d", n), timeout_err, 1'b0);
        end
        tick();
        check("to_err_set", timeout_err, 1'b1);
        req_valid = 4'b0100;
        tick();
        check("to_next_ack", req_ack, 4'b0100);
        check("to_next_gid", grant_id, 2'd2);
        check("to_err_sticky", timeout_err, 1'b1);
        req_valid = 4'b0000;
        tick();
        err_clear = 1'b1;
        for (int n = 1; n < TO; n++) begin
            tick();
            check($sformatf("to_clr%0d", n), timeout_err, 1'b0);
        end
        tick();
        check("to_wins_clear", timeout_err, 1'b1);
        tick();
        check("to_cleared", timeout_err, 1'b0);
        err_clear = 1'b0;

        // All requesters held valid, 8 transfers
        do_reset();
        use_auto = 1'b1;
        req_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
`ifdef UART_ARB_FIXED_PRIORITY_EN
            exp_id = 0;
`else
            exp_id = t % 4;
`endif
            waited = 0;
            do begin tick(); waited++; end while (req_ack == 4'b0 && waited < 64);
            check($sformatf("rr%0d_seen", t), (req_ack != 4'b0), 1'b1);
            check($sformatf("rr%0d_gid", t), grant_id, exp_id);
            check($sformatf("rr%0d_byte", t), tx_byte, rb[exp_id]);
            tick();
            check($sformatf("rr%0d_start", t), tx_start, 1'b1);
        end
        req_valid = 4'b0000;

        // Reset during WAIT_DONE
        use_auto = 1'b0; busy_man = 1'b0;
        do_reset();
        rb[0] = 8'h11; rb[3] = 8'h33;
        for (int rep = 0; rep < 2; rep++) begin
            req_valid = 4'b0100;
            tick();
            check($sformatf("wd%0d_ack", rep), req_ack, 4'b0100);
            req_valid = 4'b0000;
            tick();
            busy_man = 1'b1;
            tick();
            if (rep == 0) begin
                busy_man = 1'b0;
                tick();
            end
        end
        tick();
        reset = 1'b1; req_valid = 4'b1001; busy_man = 1'b0;
        tick();
        check("wdr_ack", req_ack, 4'b0);
        check("wdr_start", tx_start, 1'b0);
        check("wdr_byte", tx_byte, 8'h00);
        check("wdr_gid", grant_id, 2'd0);
        check("wdr_err", timeout_err, 1'b0);
        reset = 1'b0;
        tick();
        check("wdr_first_ack", req_ack, 4'b0001);
        check("wdr_first_byte", tx_byte, 8'h11);
        req_valid = 4'b1000;
        tick();
        check("wdr_first_start", tx_start, 1'b1);
        busy_man = 1'b1;
        tick();
        busy_man = 1'b0;
        tick();
        tick();
        check("wdr_second_ack", req_ack, 4'b1000);
        check("wdr_second_byte", tx_byte, 8'h33);
        req_valid = 4'b0000;
        tick(); tick(); tick();

        // Randomized traffic against the transaction-level model
        do_reset();
        use_auto = 1'b1;
        in_flight = 1'b0; seen_busy = 1'b0; pending_start = 1'b0; have_grant = 1'b0;
        m_last = 3; m_gid = 0; m_byte = 8'h00; acks = 0;
        for (int c = 0; c < 1500; c++) begin
            pv = req_valid; pb = tx_busy; pbytes = rb;
            tick();
            if (pending_start) begin
                check("rnd_start", tx_start, 1'b1);
                pending_start = 1'b0;
            end
            if (!in_flight && pv != 4'b0 && !pb) begin
                w = pick(pv, m_last);
                check("rnd_ack", req_ack, 4'b0001 << w);
                check("rnd_gid", grant_id, w);
                check("rnd_byte", tx_byte, pbytes[w]);
                m_gid = w; m_byte = pbytes[w];
                in_flight = 1'b1; seen_busy = 1'b0; pending_start = 1'b1; have_grant = 1'b1;
                acks++;
                req_valid[w] = 1'b0;
                uart_gap = $urandom_range(1, 8);
                uart_len = $urandom_range(1, 12);
            end else begin
                check("rnd_noack", req_ack, 4'b0);
                if (in_flight) begin
                    if (pb) seen_busy = 1'b1;
                    else if (seen_busy) begin
                        in_flight = 1'b0;
                        m_last = m_gid;
                    end
                end
            end
            if (have_grant) begin
                check("rnd_hold_byte", tx_byte, m_byte);
                check("rnd_hold_gid", grant_id, m_gid);
            end
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
                    rb[i] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
        end
        check("rnd_progress", (acks > 20), 1'b1);
        check("rnd_no_err", timeout_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
